// File: rtl/line_buffer_feeder.sv
// Raster-to-column feeder for a 3x3 window: two line buffers turn a pixel stream
// into vertical 3-pixel columns with masking of rows not yet filled this frame.
module line_buffer_feeder #(
   parameter int WID   = 16,
   parameter int MAX_W = 32,
   parameter int CW    = 6
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           start,
   input  logic [CW-1:0]  row_len,
   input  logic [CW-1:0]  num_rows,
   input  logic           in_valid,
   input  logic [WID-1:0] in_data,
   output logic           in_ready,
   output logic [WID-1:0] col_top,
   output logic [WID-1:0] col_mid,
   output logic [WID-1:0] col_bot,
   output logic           shifting,
   output logic           win_valid,
   output logic           busy,
   output logic           done
);

   localparam int AW = (MAX_W > 1) ? $clog2(MAX_W) : 1;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]    state_q, state_d;
   logic [CW-1:0] col_q, col_d;
   logic [CW-1:0] row_q, row_d;
   logic [CW-1:0] len_q, len_d;
   logic [CW-1:0] rows_q, rows_d;

   logic [WID-1:0] top_q, mid_q, bot_q;
   logic           shift_q, win_q;

   logic [WID-1:0] lb1 [MAX_W];
   logic [WID-1:0] lb2 [MAX_W];

   logic          accept;
   logic          last_col;
   logic [AW-1:0] addr;

   assign accept   = in_valid && (state_q == S_RUN);
   assign last_col = (col_q == len_q - CW'(1));
   assign addr     = col_q[AW-1:0];

   always_comb begin
      // NOTE: every next-state variable gets a default first so no path infers a latch.
      state_d = state_q;
      col_d   = col_q;
      row_d   = row_q;
      len_d   = len_q;
      rows_d  = rows_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_RUN;
               len_d   = row_len;
               rows_d  = num_rows;
               col_d   = '0;
               row_d   = '0;
            end
         end
         S_RUN: begin
            if (accept) begin
               if (last_col) begin
                  col_d = '0;
                  row_d = row_q + CW'(1);
                  if (row_q == rows_q - CW'(1)) state_d = S_DONE;
               end else begin
                  col_d = col_q + CW'(1);
               end
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         col_q   <= '0;
         row_q   <= '0;
         len_q   <= '0;
         rows_q  <= '0;
      end else begin
         state_q <= state_d;
         col_q   <= col_d;
         row_q   <= row_d;
         len_q   <= len_d;
         rows_q  <= rows_d;
      end
   end

   // Column registers hold between accepted pixels; rows not yet written this frame read as 0.
   always_ff @(posedge clk) begin
      if (rst) begin
         top_q   <= '0;
         mid_q   <= '0;
         bot_q   <= '0;
         shift_q <= 1'b0;
         win_q   <= 1'b0;
      end else if (accept) begin
         bot_q   <= in_data;
         mid_q   <= (row_q != '0)       ? lb1[addr] : '0;
         top_q   <= (row_q >= CW'(2))   ? lb2[addr] : '0;
         shift_q <= 1'b1;
         win_q   <= (row_q >= CW'(2)) && (col_q >= CW'(2));
      end else begin
         shift_q <= 1'b0;
         win_q   <= 1'b0;
      end
   end

   // NOTE: line buffers are deliberately not reset; the output masking hides stale contents.
   always_ff @(posedge clk) begin
      if (accept) begin
         lb2[addr] <= lb1[addr];
         lb1[addr] <= in_data;
      end
   end

   assign in_ready  = (state_q == S_RUN);
   assign busy      = (state_q == S_RUN);
   assign done      = (state_q == S_DONE);
   assign col_top   = top_q;
   assign col_mid   = mid_q;
   assign col_bot   = bot_q;
   assign shifting  = shift_q;
   assign win_valid = win_q;

endmodule

// File: tb/tb_line_buffer_feeder.sv
// Scoreboard bench for line_buffer_feeder: expected columns are queued at acceptance
// and compared against the DUT outputs on the following falling edge.
module tb_line_buffer_feeder;

   localparam int WID   = 16;
   localparam int MAX_W = 32;
   localparam int CW    = 6;

   typedef struct packed {
      logic [WID-1:0] top;
      logic [WID-1:0] mid;
      logic [WID-1:0] bot;
      logic           win;
      logic           last;
   } exp_t;

   logic           clk = 1'b0;
   logic           rst, start, in_valid;
   logic [CW-1:0]  row_len, num_rows;
   logic [WID-1:0] in_data;
   logic           in_ready, shifting, win_valid, busy, done;
   logic [WID-1:0] col_top, col_mid, col_bot;

   line_buffer_feeder #(.WID(WID), .MAX_W(MAX_W), .CW(CW)) dut (
      .clk(clk), .rst(rst), .start(start), .row_len(row_len), .num_rows(num_rows),
      .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .col_top(col_top), .col_mid(col_mid), .col_bot(col_bot),
      .shifting(shifting), .win_valid(win_valid), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   exp_t           q[$];
   int             n_cmp = 0, n_bad = 0;
   int             shift_cnt = 0, win_cnt = 0;
   bit             mon_en = 1'b0;
   logic [WID-1:0] hold_top = '0, hold_mid = '0, hold_bot = '0;

   logic [WID-1:0] hist [0:7][0:MAX_W-1];
   int             m_r, m_c, m_rl, m_nr;

   always @(negedge clk) begin
      exp_t e;
      logic exp_sh, exp_win, exp_done;
      if (mon_en) begin
         exp_sh = (q.size() != 0);
         exp_win = 1'b0;
         exp_done = 1'b0;
         if (exp_sh) begin
            e = q.pop_front();
            hold_top = e.top;
            hold_mid = e.mid;
            hold_bot = e.bot;
            exp_win  = e.win;
            exp_done = e.last;
         end
         n_cmp++;
         if (shifting !== exp_sh) begin
            n_bad++; $display("FAIL shifting: got %b want %b at %0t", shifting, exp_sh, $time);
         end
         n_cmp++;
         if (col_top !== hold_top) begin
            n_bad++; $display("FAIL col_top: got %0d want %0d at %0t", col_top, hold_top, $time);
         end
         n_cmp++;
         if (col_mid !== hold_mid) begin
            n_bad++; $display("FAIL col_mid: got %0d want %0d at %0t", col_mid, hold_mid, $time);
         end
         n_cmp++;
         if (col_bot !== hold_bot) begin
            n_bad++; $display("FAIL col_bot: got %0d want %0d at %0t", col_bot, hold_bot, $time);
         end
         n_cmp++;
         if (win_valid !== exp_win) begin
            n_bad++; $display("FAIL win_valid: got %b want %b at %0t", win_valid, exp_win, $time);
         end
         n_cmp++;
         if (done !== exp_done) begin
            n_bad++; $display("FAIL done: got %b want %b at %0t", done, exp_done, $time);
         end
         if (shifting === 1'b1) shift_cnt++;
         if (win_valid === 1'b1) win_cnt++;
      end
   end

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0;
      row_len = '0; num_rows = '0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      n_cmp++;
      if ({col_top, col_mid, col_bot} !== '0 || shifting !== 1'b0 || win_valid !== 1'b0) begin
         n_bad++; $display("FAIL reset_outputs: got %0h/%0h/%0h sh=%b wv=%b want all 0",
                           col_top, col_mid, col_bot, shifting, win_valid);
      end
      n_cmp++;
      if ({busy, done, in_ready} !== 3'b000) begin
         n_bad++; $display("FAIL reset_status: got busy/done/rdy=%b%b%b want 000", busy, done, in_ready);
      end
      hold_top = '0; hold_mid = '0; hold_bot = '0;
      mon_en = 1'b1;
   endtask

   task automatic start_frame(input int rl, input int nr);
      start = 1'b1; row_len = CW'(rl); num_rows = CW'(nr);
      @(posedge clk);
      #1 start = 1'b0;
      m_r = 0; m_c = 0; m_rl = rl; m_nr = nr;
      n_cmp++;
      if (busy !== 1'b1 || in_ready !== 1'b1) begin
         n_bad++; $display("FAIL start_run: got busy=%b rdy=%b want 1 1", busy, in_ready);
      end
   endtask

   task automatic feed(input int n, input int base, input bit gaps, input int start_at);
      exp_t e;
      for (int k = 1; k <= n; k++) begin
         n_cmp++;
         if (in_ready !== 1'b1) begin
            n_bad++; $display("FAIL in_ready: got %b want 1 before pixel %0d", in_ready, k);
         end
         in_valid = 1'b1;
         in_data  = WID'(base + k);
         if (k == start_at) begin
            start = 1'b1; row_len = CW'(5); num_rows = CW'(7);
         end
         @(posedge clk);
         e.bot  = WID'(base + k);
         e.mid  = (m_r >= 1) ? hist[m_r-1][m_c] : '0;
         e.top  = (m_r >= 2) ? hist[m_r-2][m_c] : '0;
         e.win  = (m_r >= 2) && (m_c >= 2);
         e.last = (m_r == m_nr - 1) && (m_c == m_rl - 1);
         q.push_back(e);
         hist[m_r][m_c] = WID'(base + k);
         if (m_c == m_rl - 1) begin
            m_c = 0; m_r++;
         end else begin
            m_c++;
         end
         #1 in_valid = 1'b0; start = 1'b0;
         if (gaps && k != n) begin
            @(posedge clk);
            #1;
         end
      end
   endtask

   // Called #1 after the edge that accepted the frame's last pixel.
   task automatic finish_frame(input string tag);
      n_cmp++;
      if (done !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b0) begin
         n_bad++; $display("FAIL %s_done: got done=%b busy=%b rdy=%b want 1 0 0", tag, done, busy, in_ready);
      end
      @(posedge clk);
      #1;
      n_cmp++;
      if (done !== 1'b0 || busy !== 1'b0 || q.size() != 0) begin
         n_bad++; $display("FAIL %s_idle: got done=%b busy=%b pending=%0d want 0 0 0", tag, done, busy, q.size());
      end
   endtask

   task automatic check_counts(input string tag, input int s0, input int w0, input int sh, input int wv);
      n_cmp++;
      if (shift_cnt - s0 != sh) begin
         n_bad++; $display("FAIL %s_shift_count: got %0d want %0d", tag, shift_cnt - s0, sh);
      end
      n_cmp++;
      if (win_cnt - w0 != wv) begin
         n_bad++; $display("FAIL %s_win_count: got %0d want %0d", tag, win_cnt - w0, wv);
      end
   endtask

   task automatic test_basic();
      int s0 = shift_cnt, w0 = win_cnt;
      start_frame(4, 3);
      feed(12, 0, 1'b0, 0);
      finish_frame("basic");
      check_counts("basic", s0, w0, 12, 2);
   endtask

   task automatic test_gaps();
      int s0 = shift_cnt, w0 = win_cnt;
      start_frame(4, 3);
      feed(12, 0, 1'b1, 0);
      finish_frame("gaps");
      check_counts("gaps", s0, w0, 12, 2);
   endtask

   task automatic test_back_to_back();
      int s0 = shift_cnt, w0 = win_cnt;
      start_frame(4, 3);
      feed(12, 0, 1'b0, 0);
      finish_frame("b2b_first");
      start_frame(4, 3);
      feed(12, 100, 1'b0, 0);
      finish_frame("b2b_second");
      check_counts("b2b", s0, w0, 24, 4);
   endtask

   task automatic test_start_in_run();
      int s0 = shift_cnt, w0 = win_cnt;
      start_frame(4, 3);
      feed(12, 40, 1'b0, 6);
      finish_frame("start_in_run");
      check_counts("start_in_run", s0, w0, 12, 2);
   endtask

   task automatic test_reset_mid_frame();
      int s0;
      start_frame(4, 3);
      feed(6, 200, 1'b0, 0);
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      q.delete();
      hold_top = '0; hold_mid = '0; hold_bot = '0;
      n_cmp++;
      if ({col_top, col_mid, col_bot} !== '0 || {shifting, win_valid, busy, done, in_ready} !== 5'b0) begin
         n_bad++; $display("FAIL midreset_state: got %0h/%0h/%0h sh/wv/busy/done/rdy=%b%b%b%b%b want all 0",
                           col_top, col_mid, col_bot, shifting, win_valid, busy, done, in_ready);
      end
      repeat (2) @(posedge clk);
      #1;
      n_cmp++;
      if (done !== 1'b0 || busy !== 1'b0) begin
         n_bad++; $display("FAIL midreset_no_done: got done=%b busy=%b want 0 0", done, busy);
      end
      s0 = shift_cnt;
      start_frame(4, 3);
      feed(12, 0, 1'b0, 0);
      finish_frame("restart");
      check_counts("restart", s0, win_cnt - 2, 12, 2);
   endtask

   task automatic test_max_width();
      int s0 = shift_cnt, w0 = win_cnt;
      start_frame(MAX_W, 3);
      feed(3 * MAX_W, 300, 1'b0, 0);
      finish_frame("max_width");
      check_counts("max_width", s0, w0, 3 * MAX_W, MAX_W - 2);
   endtask

   initial begin
      test_reset();
      test_basic();
      test_gaps();
      test_back_to_back();
      test_start_in_run();
      test_reset_mid_frame();
      test_max_width();
      repeat (2) @(posedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
